// File: rtl/adc_pwm_scanner.sv
// Round-robin ADC scanner: averages 2^AVG_LOG2 samples per channel and turns
// each average into a PWM duty that switches only on a counter period boundary.
module adc_pwm_scanner #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned PWM_W    = 8,
    parameter int unsigned CTR_LEN  = 20,
    parameter int unsigned TIMEOUT  = 4096,
    parameter int unsigned INVERT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [3:0]        channel,
    input  logic              new_sample,
    input  logic [9:0]        sample,
    input  logic [3:0]        sample_channel,
    output logic [NUM_CH-1:0] pwm_out,
    output logic [NUM_CH-1:0] err
);
    localparam int unsigned ACC_W  = 10 + AVG_LOG2;
    localparam int unsigned CNT_W  = AVG_LOG2 + 1;
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned SHIFT  = AVG_LOG2 + 10 - PWM_W;

    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT - 1);
    localparam logic [3:0]        LAST_CH  = 4'(NUM_CH - 1);

    typedef enum logic [1:0] {
        DISCARD = 2'd0,
        ACCUM   = 2'd1,
        ADVANCE = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [3:0]          channel_nxt;
    logic [ACC_W-1:0]    acc, acc_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
    logic                upd;
    logic                err_set;

    logic                accept;
    logic [ACC_W-1:0]    sum;
    logic [PWM_W-1:0]    duty_raw;
    logic [PWM_W-1:0]    duty;

    logic [CTR_LEN-1:0]  ctr;
    logic [PWM_W-1:0]    pending [NUM_CH];
    logic [PWM_W-1:0]    active  [NUM_CH];

    assign accept   = new_sample && (sample_channel == channel);
    assign sum      = acc + ACC_W'(sample);
    // Top PWM_W bits of the 10-bit average, taken straight from the sum.
    assign duty_raw = PWM_W'(sum >> SHIFT);
    assign duty     = (INVERT != 0) ? ~duty_raw : duty_raw;

    // Scan state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DISCARD;
            channel  <= '0;
            acc      <= '0;
            cnt      <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            channel  <= channel_nxt;
            acc      <= acc_nxt;
            cnt      <= cnt_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Next-state: an accepted sample always wins over a simultaneous timeout
    always_comb begin
        state_nxt   = state;
        channel_nxt = channel;
        acc_nxt     = acc;
        cnt_nxt     = cnt;
        wait_nxt    = wait_cnt;
        upd         = 1'b0;
        err_set     = 1'b0;
        case (state)
            DISCARD, ACCUM: begin
                if (accept) begin
                    wait_nxt = '0;
                    if (state == DISCARD) begin
                        state_nxt = ACCUM;
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                    end else if (cnt == LAST_CNT) begin
                        upd       = 1'b1;
                        state_nxt = ADVANCE;
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                    end else begin
                        acc_nxt = sum;
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end else if (wait_cnt == WAIT_MAX) begin
                    err_set   = 1'b1;
                    state_nxt = ADVANCE;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                end else begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            ADVANCE: begin
                channel_nxt = (channel == LAST_CH) ? 4'd0 : channel + 4'd1;
                wait_nxt    = '0;
                state_nxt   = DISCARD;
            end
            default: state_nxt = DISCARD;
        endcase
    end

    // Per-channel pending duty and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= '0;
            for (int i = 0; i < NUM_CH; i++) pending[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (channel == 4'(i)) begin
                    if (upd) begin
                        pending[i] <= duty;
                        err[i]     <= 1'b0;
                    end else if (err_set) begin
                        err[i] <= 1'b1;
                    end
                end
            end
        end
    end

    // Shared PWM counter; duties latch at the wrap so each period is whole
    always_ff @(posedge clk) begin
        if (rst) begin
            ctr     <= '0;
            pwm_out <= '0;
            for (int i = 0; i < NUM_CH; i++) active[i] <= '0;
        end else begin
            ctr <= ctr + CTR_LEN'(1);
            for (int i = 0; i < NUM_CH; i++) begin
                if (&ctr) active[i] <= pending[i];
                pwm_out[i] <= (active[i] > ctr[CTR_LEN-1 -: PWM_W]);
            end
        end
    end

endmodule

// File: tb/tb_adc_pwm_scanner.sv
// Randomized bench for adc_pwm_scanner: two instances (plain and inverted duty)
// share stimulus and are checked against a per-channel duty/err model.
module tb_adc_pwm_scanner;
    localparam int unsigned NUM_CH   = 2;
    localparam int unsigned AVG_LOG2 = 2;
    localparam int unsigned PWM_W    = 8;
    localparam int unsigned CTR_LEN  = 10;
    localparam int unsigned TIMEOUT  = 4096;
    localparam int          PERIOD   = 1 << CTR_LEN;
    localparam int          SLOT     = 1 << (CTR_LEN - PWM_W);
    localparam int          NSAMP    = 1 << AVG_LOG2;
    localparam int          DMAX     = (1 << PWM_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              new_sample = 1'b0;
    logic [9:0]        sample = '0;
    logic [3:0]        sample_channel = '0;
    logic [3:0]        channel_a, channel_b;
    logic [NUM_CH-1:0] pwm_a, pwm_b, err_a, err_b;

    int errors = 0;
    int checks = 0;

    // Model: expected duty per channel for each instance, expected err flags
    int                duty_a [NUM_CH];
    int                duty_b [NUM_CH];
    logic [NUM_CH-1:0] err_m;
    int                vals [NSAMP];
    logic [CTR_LEN-1:0] tb_ctr;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) tb_ctr <= '0;
        else     tb_ctr <= tb_ctr + 1'b1;
    end

    adc_pwm_scanner #(
        .NUM_CH(NUM_CH), .AVG_LOG2(AVG_LOG2), .PWM_W(PWM_W),
        .CTR_LEN(CTR_LEN), .TIMEOUT(TIMEOUT), .INVERT(0)
    ) u_plain (
        .clk(clk), .rst(rst), .channel(channel_a), .new_sample(new_sample),
        .sample(sample), .sample_channel(sample_channel),
        .pwm_out(pwm_a), .err(err_a)
    );

    adc_pwm_scanner #(
        .NUM_CH(NUM_CH), .AVG_LOG2(AVG_LOG2), .PWM_W(PWM_W),
        .CTR_LEN(CTR_LEN), .TIMEOUT(TIMEOUT), .INVERT(1)
    ) u_inv (
        .clk(clk), .rst(rst), .channel(channel_b), .new_sample(new_sample),
        .sample(sample), .sample_channel(sample_channel),
        .pwm_out(pwm_b), .err(err_b)
    );

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            duty_a[c] = 0;
            duty_b[c] = 0;
        end
        err_m = '0;
    endtask

    task automatic strobe(input logic [3:0] tag, input logic [9:0] val);
        new_sample     = 1'b1;
        sample_channel = tag;
        sample         = val;
        @(negedge clk);
        new_sample = 1'b0;
    endtask

    // Idle cycles and strobes tagged for some other channel
    task automatic junk(input int ch);
        int n;
        n = $urandom_range(0, 2);
        repeat (n) begin
            if ($urandom_range(0, 1) == 1)
                strobe(4'((ch + 1 + $urandom_range(0, 14)) % 16), 10'($urandom_range(0, 1023)));
            else
                @(negedge clk);
        end
    endtask

    task automatic send_samples(input int ch, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            junk(ch);
            strobe(4'(ch), 10'(vals[k]));
        end
    endtask

    task automatic finish_update(input int ch, input string name);
        int nxt;
        int s;
        int avg;
        nxt = (ch + 1) % NUM_CH;
        checks++;
        if (channel_a !== 4'(ch) || channel_b !== 4'(ch)) begin
            errors++;
            $display("FAIL %s_hold: channel %0d/%0d expected %0d", name, channel_a, channel_b, ch);
        end
        @(negedge clk);
        checks++;
        if (channel_a !== 4'(nxt) || channel_b !== 4'(nxt)) begin
            errors++;
            $display("FAIL %s_advance: channel %0d/%0d expected %0d", name, channel_a, channel_b, nxt);
        end
        s = 0;
        for (int k = 0; k < NSAMP; k++) s += vals[k];
        avg = s / NSAMP;
        duty_a[ch] = avg / (1 << (10 - PWM_W));
        duty_b[ch] = DMAX - duty_a[ch];
        err_m[ch]  = 1'b0;
        checks++;
        if (err_a !== err_m || err_b !== err_m) begin
            errors++;
            $display("FAIL %s_err: err %b/%b expected %b", name, err_a, err_b, err_m);
        end
    endtask

    task automatic send_update(input int ch, input string name);
        junk(ch);
        strobe(4'(ch), 10'($urandom_range(0, 1023)));
        send_samples(ch, 0, NSAMP - 2);
        checks++;
        if (channel_a !== 4'(ch) || channel_b !== 4'(ch)) begin
            errors++;
            $display("FAIL %s_early: channel %0d/%0d expected %0d", name, channel_a, channel_b, ch);
        end
        send_samples(ch, NSAMP - 1, NSAMP - 1);
        finish_update(ch, name);
    endtask

    // Count high cycles of every PWM output over one full counter period
    task automatic measure(input string name);
        int ha [NUM_CH];
        int hb [NUM_CH];
        int guard;
        repeat (2) @(negedge clk);
        guard = 0;
        while (tb_ctr != CTR_LEN'(1) && guard < 2 * PERIOD) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (tb_ctr != CTR_LEN'(1)) begin
            errors++;
            $display("FAIL %s_align: counter %0d expected 1", name, tb_ctr);
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                ha[c] = 0;
                hb[c] = 0;
            end
            for (int i = 0; i < PERIOD; i++) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    ha[c] += int'(pwm_a[c]);
                    hb[c] += int'(pwm_b[c]);
                end
                @(negedge clk);
            end
            for (int c = 0; c < NUM_CH; c++) begin
                checks++;
                if (ha[c] != duty_a[c] * SLOT || hb[c] != duty_b[c] * SLOT) begin
                    errors++;
                    $display("FAIL %s_pwm%0d: high %0d/%0d expected %0d/%0d", name, c,
                             ha[c], hb[c], duty_a[c] * SLOT, duty_b[c] * SLOT);
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (channel_a !== 4'd0 || channel_b !== 4'd0 || pwm_a !== '0 || pwm_b !== '0 ||
            err_a !== '0 || err_b !== '0) begin
            errors++;
            $display("FAIL %s: ch %0d/%0d pwm %b/%b err %b/%b expected 0", name,
                     channel_a, channel_b, pwm_a, pwm_b, err_a, err_b);
        end
    endtask

    task automatic test_reset();
        logic [NUM_CH-1:0] seen;
        do_reset(2);
        check_reset_outputs("reset");
        seen = '0;
        repeat (40) begin
            @(negedge clk);
            seen = seen | pwm_a | pwm_b;
        end
        checks++;
        if (seen !== '0) begin
            errors++;
            $display("FAIL reset_pwm_idle: pwm seen %b expected 0", seen);
        end
    endtask

    task automatic test_full_scale();
        for (int k = 0; k < NSAMP; k++) vals[k] = 1023;
        send_update(0, "full");
        measure("full");
    endtask

    task automatic test_ch1_avg();
        vals[0] = 100; vals[1] = 200; vals[2] = 300; vals[3] = 400;
        send_update(1, "avg");
        measure("avg");
    endtask

    task automatic test_foreign_tag();
        do_reset(2);
        for (int i = 0; i < 8; i++)
            strobe(4'(($urandom_range(0, 1) == 1) ? 3 : 1), 10'($urandom_range(0, 1023)));
        checks++;
        if (channel_a !== 4'd0 || channel_b !== 4'd0) begin
            errors++;
            $display("FAIL foreign_hold: channel %0d/%0d expected 0", channel_a, channel_b);
        end
        for (int k = 0; k < NSAMP; k++) vals[k] = $urandom_range(0, 1023);
        send_update(0, "foreign");
        measure("foreign");
    endtask

    task automatic test_random();
        do_reset(2);
        for (int it = 0; it < 3; it++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int k = 0; k < NSAMP; k++) vals[k] = $urandom_range(0, 1023);
                send_update(c, "rand");
            end
            measure("rand");
        end
    endtask

    task automatic test_timeout();
        do_reset(2);
        for (int k = 0; k < NSAMP; k++) vals[k] = $urandom_range(0, 1023);
        send_update(0, "tmo_pre0");
        for (int k = 0; k < NSAMP; k++) vals[k] = $urandom_range(0, 1023);
        send_update(1, "tmo_pre1");
        repeat (TIMEOUT - 1) @(negedge clk);
        checks++;
        if (err_a !== '0 || err_b !== '0 || channel_a !== 4'd0) begin
            errors++;
            $display("FAIL tmo_before: err %b/%b ch %0d expected 0", err_a, err_b, channel_a);
        end
        @(negedge clk);
        err_m[0] = 1'b1;
        checks++;
        if (err_a !== err_m || err_b !== err_m || channel_a !== 4'd0) begin
            errors++;
            $display("FAIL tmo_flag: err %b/%b ch %0d expected %b ch 0", err_a, err_b, channel_a, err_m);
        end
        @(negedge clk);
        checks++;
        if (channel_a !== 4'd1 || channel_b !== 4'd1) begin
            errors++;
            $display("FAIL tmo_advance: channel %0d/%0d expected 1", channel_a, channel_b);
        end
        measure("tmo_keep");
        for (int k = 0; k < NSAMP; k++) vals[k] = $urandom_range(0, 1023);
        send_update(1, "tmo_post1");
        for (int k = 0; k < NSAMP; k++) vals[k] = $urandom_range(0, 1023);
        send_update(0, "tmo_clear");
        measure("tmo_new");
    endtask

    task automatic test_reset_mid();
        int old [NSAMP];
        do_reset(2);
        for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < NSAMP; k++) vals[k] = $urandom_range(1, 1023);
            send_update(c, "mid_pre");
        end
        measure("mid_pre");
        for (int k = 0; k < NSAMP; k++) old[k] = $urandom_range(0, 1023);
        strobe(4'd0, 10'($urandom_range(0, 1023)));
        strobe(4'd0, 10'(old[0]));
        strobe(4'd0, 10'(old[1]));
        do_reset(1);
        check_reset_outputs("mid_reset");
        // Leftover samples: the first is dropped as stale, the second starts a new average
        strobe(4'd0, 10'(old[2]));
        vals[0] = old[3];
        for (int k = 1; k < NSAMP; k++) vals[k] = $urandom_range(0, 1023);
        send_samples(0, 0, NSAMP - 2);
        checks++;
        if (channel_a !== 4'd0 || channel_b !== 4'd0) begin
            errors++;
            $display("FAIL mid_partial: channel %0d/%0d expected 0", channel_a, channel_b);
        end
        measure("mid_hold");
        send_samples(0, NSAMP - 1, NSAMP - 1);
        finish_update(0, "mid_done");
        measure("mid_done");
    endtask

    initial begin
        err_m = '0;
        test_reset();
        test_full_scale();
        test_ch1_avg();
        test_foreign_tag();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_pwm_scanner.md
ADC_PWM_SCANNER -- requirements
Module: adc_pwm_scanner

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of scanned ADC channels, 1..16.
REQ-002 SHALL have parameter AVG_LOG2, default 2: log2 of the number of samples averaged per update, 0..4.
REQ-003 SHALL have parameter PWM_W, default 8: duty resolution in bits, 1..10.
REQ-004 SHALL have parameter CTR_LEN, default 20: PWM counter width, at least PWM_W.
REQ-005 SHALL have parameter TIMEOUT, default 4096: maximum cycles to wait for a matching sample.
REQ-006 SHALL have parameter INVERT, default 1: when 1, duty is the bitwise complement of the average.
REQ-007 SHALL have port clk  input  1  clock; all logic is on the rising edge.
REQ-008 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-009 SHALL have port channel  output  4  ADC channel currently requested.
REQ-010 SHALL have port new_sample  input  1  one-cycle strobe qualifying sample and sample_channel.
REQ-011 SHALL have port sample  input  10  ADC conversion result.
REQ-012 SHALL have port sample_channel  input  4  channel tag of sample.
REQ-013 SHALL have port pwm_out  output  NUM_CH  PWM outputs; bit i is driven by channel i.
REQ-014 SHALL have port err  output  NUM_CH  sticky per-channel timeout flags.

Function
REQ-015 SHALL accept a sample only when new_sample=1 and sample_channel==channel; all other strobes are ignored.
REQ-016 SHALL implement FSM states DISCARD, ACCUM and ADVANCE; reset state is DISCARD.
REQ-017 SHALL, in DISCARD, drop the first accepted sample after any channel change (stale conversion) and move to ACCUM with acc=0 and cnt=0.
REQ-018 SHALL, in ACCUM, add each accepted sample to acc (width 10+AVG_LOG2, no overflow possible) and increment cnt.
REQ-019 SHALL, when the 2^AVG_LOG2-th sample is accepted, compute avg=(acc+sample)>>AVG_LOG2 and write pending[channel]=avg[9 -: PWM_W], bitwise inverted if INVERT=1, on the same edge.
REQ-020 SHALL, on that same edge, clear err[channel] and enter ADVANCE.
REQ-021 SHALL, in ADVANCE, set channel to channel+1, wrapping from NUM_CH-1 to 0, and return to DISCARD after one cycle.
REQ-022 SHALL maintain a wait counter that resets on every accepted sample and on every channel change.
REQ-023 SHALL, if the wait counter reaches TIMEOUT in DISCARD or ACCUM, set err[channel], leave pending[channel] unchanged, discard the partial acc and enter ADVANCE.
REQ-024 SHALL run one free-running CTR_LEN-bit counter ctr shared by all channels; it wraps from all-ones to 0.
REQ-025 SHALL copy every pending[i] into active[i] only on the cycle ctr is all-ones, so a new duty first takes effect at ctr=0 (glitch-free period boundary).
REQ-026 SHALL drive pwm_out[i] = (active[i] > ctr[CTR_LEN-1 -: PWM_W]) as a registered output.
REQ-027 SHALL hold pwm_out[i] constantly 0 when active[i]=0, and high for 2^PWM_W-1 of 2^PWM_W slots when active[i] is all-ones.
REQ-028 SHALL, when a timeout and an accepted sample occur in the same cycle, give the accepted sample priority.
REQ-029 SHALL, when NUM_CH=1, keep channel=0 and still pass through ADVANCE and DISCARD between updates.

Reset
REQ-030 SHALL, while rst=1 at a clock edge, set channel=0, state=DISCARD, acc=0, cnt=0, wait counter=0, ctr=0, all pending and active duties=0, pwm_out=0 and err=0.
REQ-031 SHALL, on rst mid-accumulation, abandon the partial average with no pending update and restart at channel 0.

Verification
REQ-032 SHALL check: with NUM_CH=2, AVG_LOG2=2, PWM_W=8, CTR_LEN=10, INVERT=0, assert rst for 2 cycles -> channel=0, pwm_out=00, err=00.
REQ-033 SHALL check: on ch0, a discard sample then 4x sample=1023 -> pending0=255, channel=1 two cycles after the last sample, and pwm_out[0] high for 1020 of 1024 cycles after the next wrap.
REQ-034 SHALL check: on ch1, a discard sample then samples 100, 200, 300, 400 -> avg=250, pending1=62; with INVERT=1 -> pending1=193.
REQ-035 SHALL check: strobes tagged sample_channel=3 while channel=0 -> no accumulation and no state change.
REQ-036 SHALL check: no matching sample for TIMEOUT cycles on ch0 -> err[0]=1, channel advances and duty0 is unchanged; the next full update on ch0 -> err[0]=0.
REQ-037 SHALL check: after 2 of 4 samples, pulse rst -> all outputs at reset values and no pending change after the remaining samples arrive, until a full new sequence completes.
